// File: rtl/traffic_timer.sv
// traffic_timer: programmable seconds countdown (base / ext / yellow) that emits a one-cycle expired pulse.
// Optional build macro TIMER_FAST_SIM_EN removes the prescaler so that one clock counts as one second.
module traffic_timer #(
    parameter int unsigned TICKS_PER_SEC = 4,
    parameter int unsigned T_BASE_DEF    = 6,
    parameter int unsigned T_EXT_DEF     = 3,
    parameter int unsigned T_YEL_DEF     = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start_timer,
    input  logic [1:0] interval_sel,
    input  logic       reprogram,
    input  logic [1:0] time_param_selector,
    input  logic [3:0] time_value,
    output logic       expired,
    output logic       busy,
    output logic [3:0] remaining
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t     state;
    logic [3:0] t_base;
    logic [3:0] t_ext;
    logic [3:0] t_yel;
    logic [3:0] load_val;
    logic       sec_tick;

    // Interval parameter registers; a zero-length interval is never accepted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            t_base <= 4'(T_BASE_DEF);
            t_ext  <= 4'(T_EXT_DEF);
            t_yel  <= 4'(T_YEL_DEF);
        end else if (reprogram && (time_value != 4'd0)) begin
            case (time_param_selector)
                2'b00:   t_base <= time_value;
                2'b01:   t_ext  <= time_value;
                2'b10:   t_yel  <= time_value;
                default: ;
            endcase
        end
    end

    // Reads the pre-edge register values, so a same-edge reprogram only affects later starts.
    always_comb begin
        load_val = 4'd1;
        case (interval_sel)
            2'b00:   load_val = t_base;
            2'b01:   load_val = t_ext;
            2'b10:   load_val = t_yel;
            default: load_val = 4'd1;
        endcase
    end

`ifdef TIMER_FAST_SIM_EN
    assign sec_tick = 1'b1;
`else
    localparam int unsigned PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PW-1:0] PS_RELOAD = PW'(TICKS_PER_SEC - 1);

    logic [PW-1:0] prescaler;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prescaler <= '0;
        end else if (start_timer || ((state == RUN) && (prescaler == '0))) begin
            prescaler <= PS_RELOAD;
        end else if (state == RUN) begin
            prescaler <= prescaler - 1'b1;
        end
    end

    assign sec_tick = (prescaler == '0);
`endif

    // A start in any state wins over a coinciding expiry and restarts from a fresh load.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            remaining <= 4'd0;
            busy      <= 1'b0;
            expired   <= 1'b0;
        end else begin
            expired <= 1'b0;
            if (start_timer) begin
                state     <= RUN;
                remaining <= load_val;
                busy      <= 1'b1;
            end else if ((state == RUN) && sec_tick) begin
                if (remaining == 4'd1) begin
                    state     <= IDLE;
                    remaining <= 4'd0;
                    busy      <= 1'b0;
                    expired   <= 1'b1;
                end else begin
                    remaining <= remaining - 4'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_traffic_timer.sv
// Scoreboard bench for traffic_timer: every start pushes its expected expiry edge, and the monitor pops on each expired pulse.
module tb_traffic_timer;

`ifdef TIMER_FAST_SIM_EN
    localparam int T = 1;
`else
    localparam int T = 4;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start_timer = 1'b0;
    logic [1:0] interval_sel = 2'b00;
    logic       reprogram = 1'b0;
    logic [1:0] time_param_selector = 2'b00;
    logic [3:0] time_value = 4'd0;
    logic       expired;
    logic       busy;
    logic [3:0] remaining;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int last_k  = 0;
    int exp_q[$];
    int mon_e;

    traffic_timer #(
        .TICKS_PER_SEC(4), .T_BASE_DEF(6), .T_EXT_DEF(3), .T_YEL_DEF(2)
    ) dut (
        .clk(clk), .reset(reset), .start_timer(start_timer), .interval_sel(interval_sel),
        .reprogram(reprogram), .time_param_selector(time_param_selector), .time_value(time_value),
        .expired(expired), .busy(busy), .remaining(remaining)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int obs, input int expv);
        n_tests++;
        if (obs != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (edge %0d)", tag, obs, expv, cyc);
        end
    endtask

    // Expiry monitor: every pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        #1;
        if (expired) begin
            check("exp_while_busy", busy, 0);
            if (exp_q.size() == 0) begin
                check("spurious_exp", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                check("exp_edge", cyc, mon_e);
            end
        end else if (exp_q.size() > 0 && exp_q[0] < cyc) begin
            check("missed_exp", cyc, exp_q[0]);
            void'(exp_q.pop_front());
        end
    end

    // One start pulse, optionally with a reprogram on the same edge; n is the interval in seconds.
    task automatic go(input logic [1:0] sel, input int n, input bit rp,
                      input logic [1:0] rsel, input logic [3:0] rval);
        @(negedge clk);
        #2;
        start_timer         = 1'b1;
        interval_sel        = sel;
        reprogram           = rp;
        time_param_selector = rsel;
        time_value          = rval;
        last_k = cyc + 1;
        if (exp_q.size() > 0) void'(exp_q.pop_back());
        exp_q.push_back(last_k + n * T);
        @(posedge clk);
        #1;
        start_timer = 1'b0;
        reprogram   = 1'b0;
    endtask

    task automatic prog(input logic [1:0] rsel, input logic [3:0] rval);
        @(negedge clk);
        #2;
        reprogram           = 1'b1;
        time_param_selector = rsel;
        time_value          = rval;
        @(posedge clk);
        #1;
        reprogram = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget && exp_q.size() > 0; i++) @(negedge clk);
        #3;
        check("drain_timeout", exp_q.size(), 0);
        exp_q.delete();
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #3;
        check("rst_expired", expired, 0);
        check("rst_busy", busy, 0);
        check("rst_remaining", remaining, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Default base interval with per-cycle remaining/busy tracking.
        go(2'b00, 6, 0, 2'b00, 4'd0);
        for (int i = 0; i < 6 * T; i++) begin
            check("base_remaining", remaining, 6 - i / T);
            check("base_busy", busy, 1);
            @(posedge clk);
            #1;
        end
        wait_done(200);
        check("idle_busy", busy, 0);
        check("idle_remaining", remaining, 0);

        // Reprogram yellow to 5, then a rejected zero write.
        prog(2'b10, 4'd5);
        go(2'b10, 5, 0, 2'b00, 4'd0);
        check("yel_load", remaining, 5);
        wait_done(200);
        prog(2'b10, 4'd0);
        go(2'b10, 5, 0, 2'b00, 4'd0);
        check("yel_zero_rejected", remaining, 5);
        wait_done(200);

        // Restart mid-interval with ext; the base interval must never fire.
        go(2'b00, 6, 0, 2'b00, 4'd0);
        repeat (((T > 1) ? 10 : 3) - 1) @(negedge clk);
        go(2'b01, 3, 0, 2'b00, 4'd0);
        check("restart_load", remaining, 3);
        wait_done(200);

        // Start lands on the exact expiry edge of the running interval.
        go(2'b01, 3, 0, 2'b00, 4'd0);
        repeat (3 * T - 1) @(negedge clk);
        go(2'b10, 5, 0, 2'b00, 4'd0);
        check("coincide_edge", last_k, exp_q[0] - 5 * T + 0);
        check("coincide_busy", busy, 1);
        check("coincide_remaining", remaining, 5);
        wait_done(200);

        // Reprogram ext to 7 on the start edge: old value counted now, new one next time.
        go(2'b01, 3, 1, 2'b01, 4'd7);
        check("rp_start_old", remaining, 3);
        wait_done(200);
        go(2'b01, 7, 0, 2'b00, 4'd0);
        check("rp_start_new", remaining, 7);
        wait_done(200);

        // Reserved selectors: interval 11 loads 1 s, write to 11 is ignored.
        go(2'b11, 1, 0, 2'b00, 4'd0);
        check("reserved_load", remaining, 1);
        wait_done(200);
        prog(2'b11, 4'd9);
        go(2'b00, 6, 0, 2'b00, 4'd0);
        check("reserved_write", remaining, 6);
        wait_done(200);

        // Asynchronous reset mid-run, then defaults restored.
        go(2'b00, 6, 0, 2'b00, 4'd0);
        repeat (7) @(negedge clk);
        #2;
        reset = 1'b0;
        exp_q.delete();
        #1;
        check("arst_busy", busy, 0);
        check("arst_remaining", remaining, 0);
        check("arst_expired", expired, 0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (30) @(negedge clk);
        go(2'b01, 3, 0, 2'b00, 4'd0);
        check("default_ext", remaining, 3);
        wait_done(200);
        go(2'b10, 2, 0, 2'b00, 4'd0);
        check("default_yel", remaining, 2);
        wait_done(200);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
